// File: rtl/gpregs_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpregs_wb_arbiter
// Purpose  : Merges ALU and LSU writebacks onto the GPREGS write port; LSU
//            results wait in a small FIFO, ALU has priority.
// Options  : GPREGS_WB_BYPASS_EN adds read-port forwarding of the output stage.
// Revision : 1.0
// ============================================================================
module gpregs_wb_arbiter #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int LSU_DEPTH      = 2
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      alu_valid,
    input  logic [4:0]                alu_rd,
    input  logic [REG_DATA_WIDTH-1:0] alu_data,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [4:0]                lsu_rd,
    input  logic [REG_DATA_WIDTH-1:0] lsu_data,
    output logic [4:0]                write_reg,
    output logic [REG_DATA_WIDTH-1:0] din,
    output logic                      din_enable,
`ifdef GPREGS_WB_BYPASS_EN
    input  logic [4:0]                read_reg_0,
    input  logic [4:0]                read_reg_1,
    input  logic [REG_DATA_WIDTH-1:0] rf_dout_0,
    input  logic [REG_DATA_WIDTH-1:0] rf_dout_1,
    output logic [REG_DATA_WIDTH-1:0] fwd_dout_0,
    output logic [REG_DATA_WIDTH-1:0] fwd_dout_1,
`endif
    output logic [31:0]               pending_mask
);

    localparam int                 c_ptr_w   = $clog2(LSU_DEPTH);
    localparam int                 c_cnt_w   = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one = 1;
    localparam logic [c_cnt_w-1:0] c_cnt_one = 1;
    localparam logic [c_cnt_w-1:0] c_full    = LSU_DEPTH[c_cnt_w-1:0];

    logic [4:0]                r_fifo_rd   [LSU_DEPTH];
    logic [REG_DATA_WIDTH-1:0] r_fifo_data [LSU_DEPTH];
    logic [LSU_DEPTH-1:0]      r_fifo_valid;
    logic [LSU_DEPTH-1:0]      r_fifo_killed;
    logic [c_ptr_w-1:0]        r_wr_ptr;
    logic [c_ptr_w-1:0]        r_rd_ptr;
    logic [c_cnt_w-1:0]        r_count;
    logic                      r_ready_en;
    logic [4:0]                r_write_reg;
    logic [REG_DATA_WIDTH-1:0] r_din;
    logic                      r_din_enable;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_alu_kill;
    logic                      w_sel_load;
    logic                      w_sel_en;
    logic [4:0]                w_sel_rd;
    logic [REG_DATA_WIDTH-1:0] w_sel_data;
    logic [31:0]               w_pending;

    // Readiness depends only on registered occupancy, so a full FIFO never
    // accepts a push even if it pops in the same cycle.
    assign lsu_ready  = r_ready_en && (r_count != c_full);
    assign w_push     = lsu_valid && lsu_ready;
    assign w_pop      = !alu_valid && (r_count != '0);
    assign w_alu_kill = alu_valid && (alu_rd != 5'd0);

    always_comb begin
        w_sel_load = 1'b0;
        w_sel_en   = 1'b0;
        w_sel_rd   = r_write_reg;
        w_sel_data = r_din;
        if (alu_valid) begin
            w_sel_load = 1'b1;
            w_sel_en   = (alu_rd != 5'd0);
            w_sel_rd   = alu_rd;
            w_sel_data = alu_data;
        end else if (w_pop) begin
            w_sel_load = 1'b1;
            w_sel_en   = !r_fifo_killed[r_rd_ptr] && (r_fifo_rd[r_rd_ptr] != 5'd0);
            w_sel_rd   = r_fifo_rd[r_rd_ptr];
            w_sel_data = r_fifo_data[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i < LSU_DEPTH; i++) begin
                r_fifo_rd[i]   <= '0;
                r_fifo_data[i] <= '0;
            end
            r_fifo_valid  <= '0;
            r_fifo_killed <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_ready_en    <= 1'b0;
            r_write_reg   <= '0;
            r_din         <= '0;
            r_din_enable  <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            // A younger ALU write makes any queued write to the same rd dead.
            for (int i = 0; i < LSU_DEPTH; i++) begin
                if (w_alu_kill && r_fifo_valid[i] && (r_fifo_rd[i] == alu_rd))
                    r_fifo_killed[i] <= 1'b1;
            end
            if (w_push) begin
                r_fifo_rd[r_wr_ptr]     <= lsu_rd;
                r_fifo_data[r_wr_ptr]   <= lsu_data;
                r_fifo_valid[r_wr_ptr]  <= 1'b1;
                r_fifo_killed[r_wr_ptr] <= w_alu_kill && (lsu_rd == alu_rd);
                r_wr_ptr                <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_fifo_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr               <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop)
                r_count <= r_count + c_cnt_one;
            else if (!w_push && w_pop)
                r_count <= r_count - c_cnt_one;
            if (w_sel_load) begin
                r_write_reg <= w_sel_rd;
                r_din       <= w_sel_data;
            end
            r_din_enable <= w_sel_en;
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < LSU_DEPTH; i++) begin
            if (r_fifo_valid[i] && !r_fifo_killed[i])
                w_pending[r_fifo_rd[i]] = 1'b1;
        end
        if (r_din_enable)
            w_pending[r_write_reg] = 1'b1;
        w_pending[0] = 1'b0;
    end

    assign pending_mask = w_pending;
    assign write_reg    = r_write_reg;
    assign din          = r_din;
    assign din_enable   = r_din_enable;

`ifdef GPREGS_WB_BYPASS_EN
    // Covers the commit cycle, when GPREGS still presents the old value.
    assign fwd_dout_0 = (r_din_enable && (read_reg_0 != 5'd0) && (read_reg_0 == r_write_reg))
                        ? r_din : rf_dout_0;
    assign fwd_dout_1 = (r_din_enable && (read_reg_1 != 5'd0) && (read_reg_1 == r_write_reg))
                        ? r_din : rf_dout_1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpregs_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpregs_wb_arbiter
// Purpose  : Scenario bench for gpregs_wb_arbiter with a write scoreboard.
// Revision : 1.0
// ============================================================================
module tb_gpregs_wb_arbiter;

    logic        clk = 1'b0;
    logic        nreset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [4:0]  write_reg;
    logic [31:0] din;
    logic        din_enable;
    logic [31:0] pending_mask;
`ifdef GPREGS_WB_BYPASS_EN
    logic [4:0]  read_reg_0;
    logic [4:0]  read_reg_1;
    logic [31:0] rf_dout_0;
    logic [31:0] rf_dout_1;
    logic [31:0] fwd_dout_0;
    logic [31:0] fwd_dout_1;
`endif

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    wr_t         exp_wr;
    logic [31:0] tb_regs [32];
    int          compared   = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    gpregs_wb_arbiter #(.REG_DATA_WIDTH(32), .LSU_DEPTH(2)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .write_reg    (write_reg),
        .din          (din),
        .din_enable   (din_enable),
`ifdef GPREGS_WB_BYPASS_EN
        .read_reg_0   (read_reg_0),
        .read_reg_1   (read_reg_1),
        .rf_dout_0    (rf_dout_0),
        .rf_dout_1    (rf_dout_1),
        .fwd_dout_0   (fwd_dout_0),
        .fwd_dout_1   (fwd_dout_1),
`endif
        .pending_mask (pending_mask)
    );

    // Register-file model: commits at the edge ending the output cycle.
    always @(posedge clk) begin
        if (din_enable === 1'b1)
            tb_regs[write_reg] <= din;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        lsu_valid = 1'b0;
        lsu_rd    = '0;
        lsu_data  = '0;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        idle_inputs();
        step();
        step();
        compared++;
        if (din_enable !== 1'b0 || pending_mask !== 32'h0 || lsu_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_hold: din_enable=%b pending_mask=%h lsu_ready=%b, required 0/00000000/0",
                     din_enable, pending_mask, lsu_ready);
        end
        nreset = 1'b1;
        step();
        compared++;
        if (din_enable !== 1'b0 || pending_mask !== 32'h0 || lsu_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_release: din_enable=%b pending_mask=%h lsu_ready=%b, required 0/00000000/1",
                     din_enable, pending_mask, lsu_ready);
        end
    endtask

    task automatic test_alu_alone();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h12;
        sb.push_back('{rd: 5'd1, data: 32'h12});
        step();
        idle_inputs();
        compared++;
        if (din_enable !== 1'b1 || write_reg !== 5'd1 || din !== 32'h12 || pending_mask !== 32'h2) begin
            mismatched++;
            $display("FAIL alu_latency: en=%b reg=%0d din=%h mask=%h, required 1/1/00000012/00000002",
                     din_enable, write_reg, din, pending_mask);
        end
        step();
        compared++;
        if (tb_regs[1] !== 32'h12 || din_enable !== 1'b0) begin
            mismatched++;
            $display("FAIL alu_commit: x1=%h en=%b, required 00000012/0", tb_regs[1], din_enable);
        end
    endtask

    task automatic test_contention();
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hA;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'hB;
        sb.push_back('{rd: 5'd2, data: 32'hA});
        sb.push_back('{rd: 5'd3, data: 32'hB});
        step();
        idle_inputs();
        compared++;
        if (write_reg !== 5'd2 || din_enable !== 1'b1 || pending_mask !== 32'hC) begin
            mismatched++;
            $display("FAIL contention_alu: reg=%0d en=%b mask=%h, required 2/1/0000000c",
                     write_reg, din_enable, pending_mask);
        end
        step();
        compared++;
        if (write_reg !== 5'd3 || din !== 32'hB || din_enable !== 1'b1 || pending_mask !== 32'h8) begin
            mismatched++;
            $display("FAIL contention_lsu: reg=%0d din=%h en=%b mask=%h, required 3/0000000b/1/00000008",
                     write_reg, din, din_enable, pending_mask);
        end
        step();
        compared++;
        if (din_enable !== 1'b0 || pending_mask !== 32'h0) begin
            mismatched++;
            $display("FAIL contention_drain: en=%b mask=%h, required 0/00000000", din_enable, pending_mask);
        end
    endtask

    task automatic test_fifo_full();
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'd100;
        lsu_valid = 1'b1; lsu_rd = 5'd4;  lsu_data = 32'h44;
        sb.push_back('{rd: 5'd10, data: 32'd100});
        step();
        alu_rd = 5'd11; alu_data = 32'd101;
        lsu_rd = 5'd5;  lsu_data = 32'h55;
        sb.push_back('{rd: 5'd11, data: 32'd101});
        compared++;
        if (lsu_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL full_one_entry: lsu_ready=%b, required 1", lsu_ready);
        end
        step();
        lsu_valid = 1'b0;
        alu_rd = 5'd12; alu_data = 32'd102;
        sb.push_back('{rd: 5'd12, data: 32'd102});
        sb.push_back('{rd: 5'd4, data: 32'h44});
        sb.push_back('{rd: 5'd5, data: 32'h55});
        compared++;
        if (lsu_ready !== 1'b0 || pending_mask !== 32'h830) begin
            mismatched++;
            $display("FAIL full_two_entries: lsu_ready=%b mask=%h, required 0/00000830", lsu_ready, pending_mask);
        end
        step();
        alu_valid = 1'b0;
        compared++;
        if (lsu_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL full_while_alu: lsu_ready=%b, required 0", lsu_ready);
        end
        step();
        compared++;
        if (lsu_ready !== 1'b1 || write_reg !== 5'd4 || din_enable !== 1'b1) begin
            mismatched++;
            $display("FAIL full_first_pop: lsu_ready=%b reg=%0d en=%b, required 1/4/1",
                     lsu_ready, write_reg, din_enable);
        end
        step();
        compared++;
        if (write_reg !== 5'd5 || din !== 32'h55) begin
            mismatched++;
            $display("FAIL full_second_pop: reg=%0d din=%h, required 5/00000055", write_reg, din);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_kill();
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'd1;
        step();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'd2;
        sb.push_back('{rd: 5'd6, data: 32'd2});
        compared++;
        if (pending_mask !== 32'h40 || din_enable !== 1'b0) begin
            mismatched++;
            $display("FAIL kill_queued: mask=%h en=%b, required 00000040/0", pending_mask, din_enable);
        end
        step();
        idle_inputs();
        compared++;
        if (write_reg !== 5'd6 || din !== 32'd2 || pending_mask !== 32'h40) begin
            mismatched++;
            $display("FAIL kill_alu_write: reg=%0d din=%h mask=%h, required 6/00000002/00000040",
                     write_reg, din, pending_mask);
        end
        step();
        compared++;
        if (din_enable !== 1'b0 || pending_mask !== 32'h0 || tb_regs[6] !== 32'd2) begin
            mismatched++;
            $display("FAIL kill_silent_pop: en=%b mask=%h x6=%h, required 0/00000000/00000002",
                     din_enable, pending_mask, tb_regs[6]);
        end
        // Same-cycle ALU and LSU to one register: the LSU entry is stored dead.
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'd3;
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'd4;
        sb.push_back('{rd: 5'd8, data: 32'd3});
        step();
        idle_inputs();
        compared++;
        if (pending_mask !== 32'h100) begin
            mismatched++;
            $display("FAIL kill_same_cycle_mask: mask=%h, required 00000100", pending_mask);
        end
        step();
        step();
        compared++;
        if (din_enable !== 1'b0 || pending_mask !== 32'h0 || tb_regs[8] !== 32'd3) begin
            mismatched++;
            $display("FAIL kill_same_cycle: en=%b mask=%h x8=%h, required 0/00000000/00000003",
                     din_enable, pending_mask, tb_regs[8]);
        end
    endtask

    task automatic test_x0();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF;
        step();
        idle_inputs();
        compared++;
        if (din_enable !== 1'b0 || pending_mask !== 32'h0) begin
            mismatched++;
            $display("FAIL x0_alu: en=%b mask=%h, required 0/00000000", din_enable, pending_mask);
        end
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h77;
        step();
        idle_inputs();
        compared++;
        if (pending_mask !== 32'h0 || din_enable !== 1'b0) begin
            mismatched++;
            $display("FAIL x0_lsu_queued: mask=%h en=%b, required 00000000/0", pending_mask, din_enable);
        end
        step();
        compared++;
        if (din_enable !== 1'b0 || lsu_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL x0_lsu_pop: en=%b lsu_ready=%b, required 0/1", din_enable, lsu_ready);
        end
    endtask

`ifdef GPREGS_WB_BYPASS_EN
    task automatic test_bypass();
        read_reg_0 = 5'd7; rf_dout_0 = 32'hDEAD;
        read_reg_1 = 5'd0; rf_dout_1 = 32'hBEEF;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'd5;
        sb.push_back('{rd: 5'd7, data: 32'd5});
        step();
        idle_inputs();
        compared++;
        if (fwd_dout_0 !== 32'd5 || fwd_dout_1 !== 32'hBEEF) begin
            mismatched++;
            $display("FAIL bypass_commit: fwd0=%h fwd1=%h, required 00000005/0000beef", fwd_dout_0, fwd_dout_1);
        end
        step();
        compared++;
        if (fwd_dout_0 !== 32'hDEAD) begin
            mismatched++;
            $display("FAIL bypass_idle: fwd0=%h, required 0000dead", fwd_dout_0);
        end
    endtask
`endif

    initial begin
`ifdef GPREGS_WB_BYPASS_EN
        read_reg_0 = '0; read_reg_1 = '0; rf_dout_0 = '0; rf_dout_1 = '0;
`endif
        nreset = 1'b0;
        idle_inputs();
        fork
            forever begin
                @(negedge clk);
                if (din_enable === 1'b1) begin
                    compared++;
                    if (sb.size() == 0) begin
                        mismatched++;
                        $display("FAIL sb_unexpected: reg=%0d din=%h, required no write", write_reg, din);
                    end else begin
                        exp_wr = sb.pop_front();
                        if (write_reg !== exp_wr.rd || din !== exp_wr.data) begin
                            mismatched++;
                            $display("FAIL sb_write: reg=%0d din=%h, required reg=%0d din=%h",
                                     write_reg, din, exp_wr.rd, exp_wr.data);
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_alu_alone();
        test_contention();
        test_fifo_full();
        test_kill();
        test_x0();
`ifdef GPREGS_WB_BYPASS_EN
        test_bypass();
`endif
        repeat (4) step();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL sb_drain: %0d writes outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
